seq_stage_controller: RTL and testbench

//  Sequences the single-cycle-per-stage SEQ Y86-64 datapath: steps FETCH, DECODE, EXECUTE,

---
 rtl/seq_stage_controller_pkg.sv | 66 ++++++
 rtl/seq_stage_controller_if.sv | 25 ++
 rtl/seq_stage_controller_mem_wait_timer.sv | 41 ++++
 rtl/seq_stage_controller.sv | 127 ++++++++++++
 tb/tb_seq_stage_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_stage_controller_pkg.sv
// Shared Y86-64 SEQ definitions: instruction codes, status codes, stage states
// and stage-enable bit positions used by the controller, fetch and PC-update logic.
package y86_seq_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam int SE_FET = 0;
    localparam int SE_DEC = 1;
    localparam int SE_EX  = 2;
    localparam int SE_MEM = 3;
    localparam int SE_WB  = 4;
    localparam int SE_PCU = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PC_UPDATE = 3'd6,
        ST_HALTED    = 3'd7
    } stage_state_e;

    // Instructions that touch data memory and therefore handshake in MEMORY.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        logic r;
        case (ic)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] stage_decode(input stage_state_e st);
        logic [5:0] se;
        se = 6'b000000;
        case (st)
            ST_FETCH:     se[SE_FET] = 1'b1;
            ST_DECODE:    se[SE_DEC] = 1'b1;
            ST_EXECUTE:   se[SE_EX]  = 1'b1;
            ST_MEMORY:    se[SE_MEM] = 1'b1;
            ST_WRITEBACK: se[SE_WB]  = 1'b1;
            ST_PC_UPDATE: se[SE_PCU] = 1'b1;
            default:      se = 6'b000000;
        endcase
        return se;
    endfunction

endpackage

// File: rtl/seq_stage_controller_if.sv
// Handshake/status bundle between the SEQ datapath (master) and the stage controller (slave).
interface seq_stage_controller_if;
    logic        start;
    logic [3:0]  icode;
    logic        instr_invalid;
    logic        imem_error;
    logic        mem_ready;
    logic        dmem_error;
    logic [63:0] next_pc;
    logic [63:0] pc;
    logic [5:0]  stage_en;
    logic [1:0]  status;
    logic        halted;
    logic [63:0] retired_count;

    modport master (
        output start, icode, instr_invalid, imem_error, mem_ready, dmem_error, next_pc,
        input  pc, stage_en, status, halted, retired_count
    );

    modport slave (
        input  start, icode, instr_invalid, imem_error, mem_ready, dmem_error, next_pc,
        output pc, stage_en, status, halted, retired_count
    );
endinterface

// File: rtl/seq_stage_controller_mem_wait_timer.sv
// Counts cycles spent waiting for mem_ready in MEMORY and flags the cycle in
// which the wait budget runs out.
module seq_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic wait_i,
    input  logic clear_i,
    output logic timeout_o
);
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Timeout fires on the waiting cycle that would bring the count to MEM_TIMEOUT.
    assign timeout_o = wait_i && (count_q == LAST);

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (wait_i) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/seq_stage_controller.sv
// SEQ Y86-64 stage sequencer: one-hot stage enables, architectural PC,
// processor status and retired-instruction counter.
module seq_stage_controller
    import y86_seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    seq_stage_controller_if.slave  bus
);
    stage_state_e state_q, state_d;
    logic [3:0]   icode_q, icode_d;
    logic [63:0]  pc_q, pc_d;
    logic [1:0]   status_q, status_d;
    logic [63:0]  retired_q, retired_d;
    logic [5:0]   stage_en_q;
    logic         halted_q;

    logic mem_op;
    logic mem_wait;
    logic mem_clear;
    logic mem_timeout;

    assign mem_op    = is_mem_icode(icode_q);
    assign mem_wait  = (state_q == ST_MEMORY) && mem_op && !bus.mem_ready;
    assign mem_clear = (state_q == ST_MEMORY) && (state_d != ST_MEMORY);

    seq_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .wait_i    (mem_wait),
        .clear_i   (mem_clear),
        .timeout_o (mem_timeout)
    );

    // Next-state and architectural-state updates for the stage sequencer.
    always_comb begin
        state_d   = state_q;
        icode_d   = icode_q;
        pc_d      = pc_q;
        status_d  = status_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                icode_d = bus.icode;
                // Address fault outranks an illegal instruction.
                if (bus.imem_error) begin
                    status_d = STAT_ADR;
                    state_d  = ST_HALTED;
                end else if (bus.instr_invalid) begin
                    status_d = STAT_INS;
                    state_d  = ST_HALTED;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: state_d = ST_MEMORY;
            ST_MEMORY: begin
                if (!mem_op) begin
                    state_d = ST_WRITEBACK;
                end else if (bus.mem_ready) begin
                    if (bus.dmem_error) begin
                        status_d = STAT_ADR;
                        state_d  = ST_HALTED;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (mem_timeout) begin
                    status_d = STAT_ADR;
                    state_d  = ST_HALTED;
                end else begin
                    state_d = ST_MEMORY;
                end
            end
            ST_WRITEBACK: state_d = ST_PC_UPDATE;
            ST_PC_UPDATE: begin
                retired_d = retired_q + 64'd1;
                if (icode_q == IHALT) begin
                    status_d = STAT_HLT;
                    state_d  = ST_HALTED;
                end else begin
                    pc_d    = bus.next_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, architectural registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            icode_q    <= 4'h0;
            pc_q       <= RESET_PC;
            status_q   <= STAT_AOK;
            retired_q  <= 64'd0;
            stage_en_q <= 6'b000000;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            icode_q    <= icode_d;
            pc_q       <= pc_d;
            status_q   <= status_d;
            retired_q  <= retired_d;
            stage_en_q <= stage_decode(state_d);
            halted_q   <= (state_d == ST_HALTED);
        end
    end

    assign bus.pc            = pc_q;
    assign bus.stage_en      = stage_en_q;
    assign bus.status        = status_q;
    assign bus.halted        = halted_q;
    assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_seq_stage_controller.sv
// Self-checking bench for seq_stage_controller: directed table, hand sequences
// and random programs against an instruction-level latency model.
module tb_seq_stage_controller;
    import y86_seq_pkg::*;

    localparam int TMO = 16;

    logic clk;
    logic reset_n;
    seq_stage_controller_if bus();

    seq_stage_controller #(.RESET_PC(64'h0), .MEM_TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_pc;
    logic [63:0] m_ret;
    logic [1:0]  m_status;
    logic        m_halted;

    typedef struct {
        logic [3:0]  ic;
        logic        ie;
        logic        iv;
        int          wt;
        logic        de;
        int          exp_cyc;
        logic [1:0]  exp_st;
        logic [63:0] exp_ret;
        logic        exp_halt;
        logic [63:0] exp_pc;
    } row_t;

    row_t rows[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic junk();
        bus.start         = 1'($urandom_range(0, 1));
        bus.icode         = 4'($urandom_range(0, 15));
        bus.imem_error    = 1'($urandom_range(0, 1));
        bus.instr_invalid = 1'($urandom_range(0, 1));
        bus.mem_ready     = 1'($urandom_range(0, 1));
        bus.dmem_error    = 1'($urandom_range(0, 1));
        bus.next_pc       = {$urandom, $urandom};
    endtask

    task automatic zero_in();
        bus.start = 1'b0; bus.icode = 4'h0; bus.imem_error = 1'b0; bus.instr_invalid = 1'b0;
        bus.mem_ready = 1'b0; bus.dmem_error = 1'b0; bus.next_pc = 64'h0;
    endtask

    task automatic check_now(input string tag, input logic [5:0] exp_se);
        chk({tag, " stage_en"}, 64'(bus.stage_en), 64'(exp_se));
        chk({tag, " pc"}, bus.pc, m_pc);
        chk({tag, " status"}, 64'(bus.status), 64'(m_status));
        chk({tag, " halted"}, 64'(bus.halted), 64'(m_halted));
        chk({tag, " retired"}, bus.retired_count, m_ret);
    endtask

    task automatic step_check(input string tag, input logic [5:0] exp_se);
        @(negedge clk);
        check_now(tag, exp_se);
    endtask

    // Reset is held across one posedge with start=1; reset must win.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        junk();
        bus.start = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        zero_in();
        m_pc = 64'h0; m_ret = 64'd0; m_status = STAT_AOK; m_halted = 1'b0;
        check_now("reset", 6'b000000);
    endtask

    // Instruction-level model: a FETCH..PC_UPDATE walk with 3 + memory cycles + 2 stages.
    task automatic run_instr(input logic [3:0] ic, input logic ie, input logic iv,
                             input int wt, input logic de, input logic [63:0] npc);
        step_check("fet", 6'b000001);
        junk();
        bus.icode = ic; bus.imem_error = ie; bus.instr_invalid = iv;
        if (ie || iv) begin
            m_status = ie ? STAT_ADR : STAT_INS;
            m_halted = 1'b1;
            return;
        end
        step_check("dec", 6'b000010); junk();
        step_check("ex", 6'b000100); junk();
        if (!(ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB})) begin
            step_check("mem", 6'b001000); junk();
            bus.dmem_error = 1'b0;
        end else begin
            for (int k = 0; k < TMO; k++) begin
                step_check("mem", 6'b001000); junk();
                if (k == wt) begin
                    bus.mem_ready = 1'b1; bus.dmem_error = de;
                    if (de) begin
                        m_status = STAT_ADR; m_halted = 1'b1;
                        return;
                    end
                    break;
                end
                bus.mem_ready = 1'b0;
                if (k == TMO - 1) begin
                    m_status = STAT_ADR; m_halted = 1'b1;
                    return;
                end
            end
        end
        step_check("wb", 6'b010000); junk();
        step_check("pcu", 6'b100000); junk();
        bus.next_pc = npc;
        m_ret = m_ret + 64'd1;
        if (ic == 4'h0) begin
            m_status = STAT_HLT; m_halted = 1'b1;
        end else begin
            m_pc = npc;
        end
    endtask

    task automatic halted_checks(input int n);
        for (int i = 0; i < n; i++) begin
            step_check("halted", 6'b000000);
            junk();
            bus.start = 1'b1;
        end
    endtask

    // Drives one table row reactively from the observed stage and measures latency.
    task automatic run_row(input row_t r, input int idx);
        int cyc;
        int memcnt;
        bit done;
        string t;
        t = $sformatf("row%0d", idx);
        do_reset();
        bus.start = 1'b1;
        @(negedge clk);
        cyc = 0; memcnt = 0; done = 1'b0;
        for (int g = 0; g < 60 && !done; g++) begin
            if (bus.halted || (bus.stage_en == 6'b000001 && cyc > 0)) begin
                done = 1'b1;
            end else begin
                cyc++;
                zero_in();
                case (bus.stage_en)
                    6'b000001: begin
                        bus.icode = r.ic; bus.imem_error = r.ie; bus.instr_invalid = r.iv;
                    end
                    6'b001000: begin
                        bus.mem_ready = (memcnt == r.wt); bus.dmem_error = r.de; memcnt++;
                    end
                    6'b100000: bus.next_pc = bus.pc + 64'd1;
                    default: ;
                endcase
                @(negedge clk);
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s bound: no FETCH or HALTED within 60 cycles", t);
        end
        chk({t, " cycles"}, 64'(cyc), 64'(r.exp_cyc));
        chk({t, " status"}, 64'(bus.status), 64'(r.exp_st));
        chk({t, " retired"}, bus.retired_count, r.exp_ret);
        chk({t, " halted"}, 64'(bus.halted), 64'(r.exp_halt));
        chk({t, " pc"}, bus.pc, r.exp_pc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        zero_in();

        rows[0]  = '{4'h1, 1'b0, 1'b0, 0,  1'b0, 6,  STAT_AOK, 64'd1, 1'b0, 64'd1};
        rows[1]  = '{4'h5, 1'b0, 1'b0, 3,  1'b0, 9,  STAT_AOK, 64'd1, 1'b0, 64'd1};
        rows[2]  = '{4'h0, 1'b0, 1'b0, 0,  1'b0, 6,  STAT_HLT, 64'd1, 1'b1, 64'd0};
        rows[3]  = '{4'h2, 1'b1, 1'b1, 0,  1'b0, 1,  STAT_ADR, 64'd0, 1'b1, 64'd0};
        rows[4]  = '{4'h2, 1'b0, 1'b1, 0,  1'b0, 1,  STAT_INS, 64'd0, 1'b1, 64'd0};
        rows[5]  = '{4'h4, 1'b0, 1'b0, 99, 1'b0, 19, STAT_ADR, 64'd0, 1'b1, 64'd0};
        rows[6]  = '{4'hB, 1'b0, 1'b0, 0,  1'b0, 6,  STAT_AOK, 64'd1, 1'b0, 64'd1};
        rows[7]  = '{4'h8, 1'b0, 1'b0, 2,  1'b1, 6,  STAT_ADR, 64'd0, 1'b1, 64'd0};
        rows[8]  = '{4'h6, 1'b0, 1'b0, 99, 1'b0, 6,  STAT_AOK, 64'd1, 1'b0, 64'd1};
        rows[9]  = '{4'hA, 1'b0, 1'b0, 15, 1'b0, 21, STAT_AOK, 64'd1, 1'b0, 64'd1};
        rows[10] = '{4'h3, 1'b1, 1'b0, 0,  1'b0, 1,  STAT_ADR, 64'd0, 1'b1, 64'd0};

        for (int i = 0; i < 11; i++) begin
            run_row(rows[i], i);
        end

        // Three nops then halt: pc walks 0..3, halt retires without moving pc.
        do_reset();
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_instr(4'h1, 1'b0, 1'b0, 0, 1'b0, m_pc + 64'd1);
        end
        run_instr(4'h0, 1'b0, 1'b0, 0, 1'b0, 64'hDEAD);
        halted_checks(1);
        chk("t2 pc", bus.pc, 64'd3);
        chk("t2 retired", bus.retired_count, 64'd4);
        chk("t2 status", 64'(bus.status), 64'(STAT_HLT));
        halted_checks(4);

        // Reset while the second instruction is in EXECUTE.
        do_reset();
        bus.start = 1'b1;
        run_instr(4'h1, 1'b0, 1'b0, 0, 1'b0, 64'h40);
        step_check("t6 fet", 6'b000001);
        junk(); bus.icode = 4'h6; bus.imem_error = 1'b0; bus.instr_invalid = 1'b0;
        step_check("t6 dec", 6'b000010); junk();
        step_check("t6 ex", 6'b000100); junk();
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6 stage_en", 64'(bus.stage_en), 64'd0);
        chk("t6 pc", bus.pc, 64'd0);
        chk("t6 retired", bus.retired_count, 64'd0);
        chk("t6 status", 64'(bus.status), 64'(STAT_AOK));
        reset_n = 1'b1;
        zero_in();
        m_pc = 64'h0; m_ret = 64'd0; m_status = STAT_AOK; m_halted = 1'b0;
        step_check("t6 idle hold", 6'b000000);

        // Random programs against the instruction-level model.
        for (int p = 0; p < 10; p++) begin
            do_reset();
            bus.start = 1'b1;
            for (int i = 0; i < 25 && !m_halted; i++) begin
                logic [3:0] ic;
                int r;
                int wt;
                ic = 4'($urandom_range(0, 11));
                if (ic == 4'h0 && $urandom_range(0, 2) != 0) ic = 4'h1;
                r  = $urandom_range(0, 29);
                wt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
                run_instr(ic, 1'(r == 0), 1'(r <= 1), wt,
                          1'($urandom_range(0, 14) == 0), {$urandom, $urandom});
            end
            if (m_halted) begin
                halted_checks(3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
